// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator for WIDTH-bit words framed by start/valid.
// Bit order and signed/unsigned interpretation are fixed at build time.
module serial_word_comparator #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          SIGNED_MODE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic valid,
  input  logic a,
  input  logic b,
  output logic greater,
  output logic equal,
  output logic less,
  output logic done,
  output logic busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StEq = 2'b00,
    StGt = 2'b01,
    StLt = 2'b10
  } res_e;

  res_e            state_q, state_d, base;
  logic [CntW-1:0] cnt_q, cnt_d, idx;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            take, last, msb_pos, a_wins;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // A start always opens a fresh frame, discarding any frame in progress.
    idx     = start ? '0 : cnt_q;
    base    = start ? StEq : state_q;
    last    = (idx == CntW'(WIDTH - 1));
    msb_pos = MSB_FIRST ? (idx == '0) : last;
    // For a differing pair, the sign bit of a two's-complement word inverts the decision.
    a_wins  = (SIGNED_MODE && msb_pos) ? b : a;
    take    = valid & (start | busy_q);

    if (take) begin
      state_d = base;
      if (a ^ b) begin
        // MSB-first: first difference is sticky; LSB-first: later (more significant) wins.
        if (!MSB_FIRST || base == StEq) begin
          state_d = a_wins ? StGt : StLt;
        end
      end
      if (last) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        busy_d = 1'b1;
        cnt_d  = idx + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEq;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign greater = (state_q == StGt);
  assign equal   = (state_q == StEq);
  assign less    = (state_q == StLt);
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
